// File: rtl/cu_dac_interpolation.sv
// Linear-interpolating upsampler that feeds a DAC with N output samples per input sample, where N is 2, 4 or 32.
// Latency: the output register updates one edge after the Emit state; a request caught in WaitReq reaches the DAC two edges later.
// Backpressure: din_ready is high only in Idle. One early DAC request is queued. A request in Idle with no new sample repeats prev and raises underrun.
module cu_dac_interpolation (
   input  logic        clk,
   input  logic        rst,
   input  logic        din_valid,
   input  logic [15:0] datain,
   output logic        din_ready,
   input  logic [2:0]  rate,
   input  logic        dac_req,
   output logic [15:0] dataout,
   output logic        data_rdy,
   output logic        underrun
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAITREQ,
      S_EMIT,
      S_CHKCOUNT
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        prev_q, prev_d;
   logic [15:0]        cur_q, cur_d;
   logic signed [16:0] diff_q, diff_d;
   logic signed [21:0] acc_q, acc_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [5:0]         n_q, n_d;
   logic [2:0]         s_q, s_d;
   logic               req_pend_q, req_pend_d;
   logic [15:0]        dataout_q, dataout_d;
   logic               data_rdy_q, data_rdy_d;
   logic               underrun_q, underrun_d;

   // Decode the interpolation ratio N and its log2 S from the rate select.
   logic [5:0] n_sel;
   logic [2:0] s_sel;
   always_comb begin
      n_sel = 6'd32;
      s_sel = 3'd5;
      if (rate == 3'b001) begin
         n_sel = 6'd2;
         s_sel = 3'd1;
      end else if (rate == 3'b011) begin
         n_sel = 6'd4;
         s_sel = 3'd2;
      end
   end

   // State register and all datapath registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         prev_q     <= '0;
         cur_q      <= '0;
         diff_q     <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         n_q        <= 6'd2;
         s_q        <= 3'd1;
         req_pend_q <= 1'b0;
         dataout_q  <= '0;
         data_rdy_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         cur_q      <= cur_d;
         diff_q     <= diff_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         s_q        <= s_d;
         req_pend_q <= req_pend_d;
         dataout_q  <= dataout_d;
         data_rdy_q <= data_rdy_d;
         underrun_q <= underrun_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (din_valid) state_d = S_LOAD;
         S_LOAD:     state_d = S_WAITREQ;
         S_WAITREQ:  if (dac_req || req_pend_q) state_d = S_EMIT;
         S_EMIT:     state_d = S_CHKCOUNT;
         S_CHKCOUNT: state_d = (cnt_q == n_q) ? S_IDLE : S_WAITREQ;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: accumulate prev<<S + k*diff and emit the top 16 bits.
   always_comb begin
      prev_d     = prev_q;
      cur_d      = cur_q;
      diff_d     = diff_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      s_d        = s_q;
      req_pend_d = req_pend_q;
      dataout_d  = dataout_q;
      data_rdy_d = 1'b0;
      underrun_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (din_valid) begin
               // A request arriving with the sample is queued for the new block.
               cur_d = datain;
               if (dac_req) req_pend_d = 1'b1;
            end else if (dac_req || req_pend_q) begin
               // A hold-emit right after another output would make data_rdy two cycles wide, so it is deferred one cycle.
               if (data_rdy_q) begin
                  req_pend_d = 1'b1;
               end else begin
                  dataout_d  = prev_q;
                  data_rdy_d = 1'b1;
                  underrun_d = 1'b1;
                  req_pend_d = 1'b0;
               end
            end
         end
         S_LOAD: begin
            n_d    = n_sel;
            s_d    = s_sel;
            diff_d = $signed({cur_q[15], cur_q}) - $signed({prev_q[15], prev_q});
            acc_d  = $signed({{6{prev_q[15]}}, prev_q}) <<< s_sel;
            cnt_d  = '0;
            if (dac_req) req_pend_d = 1'b1;
         end
         S_WAITREQ: begin
            if (dac_req || req_pend_q) req_pend_d = 1'b0;
         end
         S_EMIT: begin
            dataout_d  = 16'(acc_q >>> s_q);
            data_rdy_d = 1'b1;
            acc_d      = acc_q + {{5{diff_q[16]}}, diff_q};
            cnt_d      = cnt_q + 6'd1;
            if (dac_req) req_pend_d = 1'b1;
         end
         S_CHKCOUNT: begin
            if (cnt_q == n_q) prev_d = cur_q;
            if (dac_req) req_pend_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Output decode: the block takes a new sample only in Idle.
   always_comb begin
      din_ready = (state_q == S_IDLE);
   end

   assign dataout  = dataout_q;
   assign data_rdy = data_rdy_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_cu_dac_interpolation.sv
// Bench for cu_dac_interpolation: a set of directed scenarios followed by randomized blocks and underruns.
// A reference queue holds each expected (value, underrun) pair, computed as prev + floor(k*(cur-prev)/N).
// Outputs are sampled on the falling edge. Inputs are driven 1 time unit after the rising edge.
module tb_cu_dac_interpolation;

   logic        clk = 1'b0;
   logic        rst;
   logic        din_valid;
   logic [15:0] datain;
   logic        din_ready;
   logic [2:0]  rate;
   logic        dac_req;
   logic [15:0] dataout;
   logic        data_rdy;
   logic        underrun;

   cu_dac_interpolation dut (
      .clk       (clk),
      .rst       (rst),
      .din_valid (din_valid),
      .datain    (datain),
      .din_ready (din_ready),
      .rate      (rate),
      .dac_req   (dac_req),
      .dataout   (dataout),
      .data_rdy  (data_rdy),
      .underrun  (underrun)
   );

   always #5 clk = ~clk;

   int n_chk   = 0;
   int n_pass  = 0;
   int rdy_cnt = 0;
   int und_cnt = 0;
   bit prev_rdy = 1'b0;
   int prev_m  = 0;
   int exp_val[$];
   int exp_und[$];

   task automatic check_eq(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   function automatic int floordiv(input int a, input int n);
      int q;
      q = a / n;
      if ((a % n) != 0 && a < 0) q = q - 1;
      return q;
   endfunction

   function automatic int ratio(input logic [2:0] r);
      if (r == 3'b001) return 2;
      if (r == 3'b011) return 4;
      return 32;
   endfunction

   // Output monitor: every data_rdy pulse is matched against the reference queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (underrun) check_eq("underrun_has_rdy", data_rdy, 1);
         if (data_rdy) begin
            rdy_cnt++;
            if (underrun) und_cnt++;
            check_eq("rdy_not_consecutive", prev_rdy, 0);
            check_eq("output_expected", exp_val.size() > 0, 1);
            if (exp_val.size() > 0) begin
               check_eq("dataout", $signed(dataout), exp_val.pop_front());
               check_eq("underrun_flag", underrun, exp_und.pop_front());
            end
         end
      end
      prev_rdy = data_rdy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input int target, input string tag);
      for (int t = 0; t < 20 && rdy_cnt < target; t++) tick();
      check_eq(tag, rdy_cnt >= target, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      exp_val.delete();
      exp_und.delete();
      prev_m = 0;
      check_eq("rst_dataout", dataout, 0);
      check_eq("rst_underrun", underrun, 0);
      tick();
      check_eq("rst_no_rdy", data_rdy, 0);
      rst = 1'b0;
      check_eq("rst_din_ready", din_ready, 1);
   endtask

   task automatic send(input int v, input logic [2:0] r, input bit with_req);
      int n;
      for (int t = 0; t < 40 && !din_ready; t++) tick();
      check_eq("din_ready_wait", din_ready, 1);
      datain    = 16'(v);
      rate      = r;
      din_valid = 1'b1;
      dac_req   = with_req;
      tick();
      din_valid = 1'b0;
      dac_req   = 1'b0;
      n = ratio(r);
      for (int k = 0; k < n; k++) begin
         exp_val.push_back(prev_m + floordiv(k * (v - prev_m), n));
         exp_und.push_back(0);
      end
      prev_m = v;
   endtask

   task automatic request(input int gap);
      int tgt;
      tgt = rdy_cnt + 1;
      dac_req = 1'b1;
      tick();
      dac_req = 1'b0;
      wait_rdy(tgt, "request_timeout");
      for (int g = 0; g < gap; g++) begin
         // A sample offered while the block is busy must be dropped.
         if (!din_ready && ($urandom_range(0, 1) == 1)) begin
            datain    = 16'($urandom);
            din_valid = 1'b1;
         end
         tick();
         din_valid = 1'b0;
      end
   endtask

   task automatic underrun_req();
      for (int t = 0; t < 40 && !din_ready; t++) tick();
      exp_val.push_back(prev_m);
      exp_und.push_back(1);
      request(1);
   endtask

   initial begin
      int base;
      int und_base;
      logic signed [15:0] rv;
      logic [2:0] rr;
      int n;
      rst = 1'b1; din_valid = 1'b0; datain = '0; rate = 3'b001; dac_req = 1'b0;
      tick();
      do_reset();

      // Two-times ramp from zero: 0, 50, 100, 150.
      send(100, 3'b001, 1'b0);
      request(1); request(0);
      send(200, 3'b001, 1'b0);
      request(2); request(0);
      // Underrun repeats the last sample.
      underrun_req();
      check_eq("underrun_count", und_cnt, 1);

      // Negative step with N=4: 0, -2, -4, -6.
      do_reset();
      send(-8, 3'b011, 1'b0);
      request(0); request(1); request(0); request(0);
      check_eq("din_ready_after_block", din_ready, 1);

      // N=32 full ramp, then a floor case 0 -> 3 with N=2.
      do_reset();
      send(32, 3'b000, 1'b0);
      for (int i = 0; i < 32; i++) request(i % 3);
      do_reset();
      send(3, 3'b001, 1'b0);
      request(0); request(0);

      // Request together with the sample, plus one request during Emit.
      base = rdy_cnt;
      und_base = und_cnt;
      send(43, 3'b011, 1'b1);
      tick(); tick();
      dac_req = 1'b1;
      tick();
      dac_req = 1'b0;
      wait_rdy(base + 2, "queued_requests_timeout");
      request(0); request(0);
      tick(); tick();
      check_eq("simultaneous_output_count", rdy_cnt - base, 4);
      check_eq("simultaneous_no_underrun", und_cnt - und_base, 0);

      // Reset in the middle of a block abandons it.
      send(80, 3'b011, 1'b0);
      request(0); request(0);
      do_reset();
      send(40, 3'b011, 1'b0);
      request(0); request(1); request(0); request(2);

      // Randomized blocks and underruns.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            underrun_req();
         end else begin
            rv = 16'($urandom);
            rr = 3'($urandom);
            send(int'(rv), rr, 1'b0);
            n = ratio(rr);
            for (int k = 0; k < n; k++) request($urandom_range(0, 2));
         end
      end

      tick(); tick(); tick();
      check_eq("queue_drained", exp_val.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
